// File: rtl/reg_file_pipe_if.sv
// Decode-stage register file bus: write-back port, packed read ports,
// scoreboard reservation, clear control and status.
interface reg_file_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic                       wr_en;
  logic [ADDR_W-1:0]          write_addr;
  logic [DATA_W-1:0]          write_data;
  logic [NUM_RD*ADDR_W-1:0]   read_addr;
  logic [NUM_RD*DATA_W-1:0]   read_data;
  logic [NUM_RD-1:0]          read_pending;
  logic                       reserve_en;
  logic [ADDR_W-1:0]          reserve_addr;
  logic                       clear_req;
  logic                       ready;
  logic                       clear_done;
  logic                       wr_drop;
  logic [DATA_W-1:0]          pc_in;

  modport master (
    output wr_en, write_addr, write_data, read_addr, reserve_en, reserve_addr,
           clear_req, pc_in,
    input  read_data, read_pending, ready, clear_done, wr_drop
  );

  modport slave (
    input  wr_en, write_addr, write_data, read_addr, reserve_en, reserve_addr,
           clear_req, pc_in,
    output read_data, read_pending, ready, clear_done, wr_drop
  );
endinterface

// File: rtl/reg_file_pipe.sv
// Register file with write-to-read bypass, pending scoreboard and sequential clear sweep.
// Optional macro REG_FILE_PC_READ_EN: address NREG-1 reads as pc_in + 8.
module reg_file_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic           clk,
  input  logic           reset,
  reg_file_pipe_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pend_q, pend_d;
  logic              clear_done_q, clear_done_d;
  logic              wr_drop_q, wr_drop_d;

  logic idle;
  logic accept;
  logic wr_accept;
  logic res_accept;

  // The clear_req edge already belongs to the sweep, so traffic on it is dropped.
  assign idle       = (state_q == ST_IDLE);
  assign accept     = idle && !bus.clear_req;
  assign wr_accept  = accept && bus.wr_en;
  assign res_accept = accept && bus.reserve_en;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    regs_d       = regs_q;
    pend_d       = pend_q;
    clear_done_d = 1'b0;
    wr_drop_d    = (bus.wr_en || bus.reserve_en) && !accept;

    if (idle) begin
      if (bus.clear_req) begin
        state_d = ST_CLEAR;
      end
      if (wr_accept) begin
        regs_d[bus.write_addr] = bus.write_data;
        pend_d[bus.write_addr] = 1'b0;
      end
      // Reserve is applied last so it wins over a same-address write.
      if (res_accept) begin
        pend_d[bus.reserve_addr] = 1'b1;
      end
    end else begin
      regs_d[idx_q] = '0;
      pend_d[idx_q] = 1'b0;
      idx_d         = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d      = ST_IDLE;
        idx_d        = '0;
        clear_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pend_q       <= '0;
      clear_done_q <= 1'b0;
      wr_drop_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      clear_done_q <= clear_done_d;
      wr_drop_q    <= wr_drop_d;
      regs_q       <= regs_d;
    end
  end

  assign bus.ready      = idle;
  assign bus.clear_done = clear_done_q;
  assign bus.wr_drop    = wr_drop_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              bypass;
    logic [DATA_W-1:0] stored;

    assign ra     = bus.read_addr[k*ADDR_W +: ADDR_W];
    assign bypass = wr_accept && (bus.write_addr == ra);
    assign stored = bypass ? bus.write_data : regs_q[ra];

`ifdef REG_FILE_PC_READ_EN
    assign bus.read_data[k*DATA_W +: DATA_W] = (ra == LAST_IDX) ? bus.pc_in + DATA_W'(8) : stored;
    assign bus.read_pending[k]               = (ra != LAST_IDX) && pend_q[ra];
`else
    assign bus.read_data[k*DATA_W +: DATA_W] = stored;
    assign bus.read_pending[k]               = pend_q[ra];
`endif
  end

`ifndef REG_FILE_PC_READ_EN
  logic unused_pc;
  assign unused_pc = ^bus.pc_in;
`endif

endmodule

// File: tb/tb_reg_file_pipe.sv
// Randomized and directed bench for reg_file_pipe against an array-based reference model.
module tb_reg_file_pipe;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;
  localparam int NREG   = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  reg_file_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_busy = 0;
  int n_done = 0;

  logic [31:0] m_mem  [NREG];
  bit          m_pend [NREG];
  bit          m_busy;
  int          m_sweep;
  bit          m_done;
  bit          m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_busy  = 1'b0;
    m_sweep = 0;
    m_done  = 1'b0;
    m_drop  = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input int a);
`ifdef REG_FILE_PC_READ_EN
    if (a == NREG - 1) return bus.pc_in + 32'd8;
`endif
    if (!m_busy && !bus.clear_req && bus.wr_en && int'(bus.write_addr) == a) return bus.write_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input int a);
`ifdef REG_FILE_PC_READ_EN
    if (a == NREG - 1) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic check_outputs();
    chk("ready", 64'(bus.ready), 64'(!m_busy));
    chk("clear_done", 64'(bus.clear_done), 64'(m_done));
    chk("wr_drop", 64'(bus.wr_drop), 64'(m_drop));
    for (int k = 0; k < NUM_RD; k++) begin
      int a;
      a = int'(bus.read_addr[k*ADDR_W +: ADDR_W]);
      chk($sformatf("rd%0d_data[r%0d]", k, a), 64'(bus.read_data[k*DATA_W +: DATA_W]), 64'(exp_rd(a)));
      chk($sformatf("rd%0d_pend[r%0d]", k, a), 64'(bus.read_pending[k]), 64'(exp_pend(a)));
    end
  endtask

  task automatic model_update();
    if (!m_busy) begin
      m_done = 1'b0;
      if (bus.clear_req) begin
        m_drop  = bus.wr_en || bus.reserve_en;
        m_busy  = 1'b1;
        m_sweep = 0;
      end else begin
        m_drop = 1'b0;
        if (bus.wr_en) begin
          m_mem[bus.write_addr]  = bus.write_data;
          m_pend[bus.write_addr] = 1'b0;
        end
        if (bus.reserve_en) m_pend[bus.reserve_addr] = 1'b1;
      end
    end else begin
      m_drop           = bus.wr_en || bus.reserve_en;
      m_mem[m_sweep]   = '0;
      m_pend[m_sweep]  = 1'b0;
      m_sweep++;
      m_done = (m_sweep == NREG);
      if (m_done) m_busy = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    n_busy += (bus.ready == 1'b0) ? 1 : 0;
    n_done += (bus.clear_done == 1'b1) ? 1 : 0;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    bus.wr_en      = 1'b0;
    bus.reserve_en = 1'b0;
    bus.clear_req  = 1'b0;
  endtask

  task automatic set_rd(input int k, input int a);
    bus.read_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    bus.write_addr   = '0;
    bus.write_data   = '0;
    bus.reserve_addr = '0;
    bus.read_addr    = '0;
    bus.pc_in        = 32'h0000_0040;
    model_reset();
    #1;
    chk("reset_ready", 64'(bus.ready), 64'd1);
    chk("reset_clear_done", 64'(bus.clear_done), 64'd0);
    chk("reset_wr_drop", 64'(bus.wr_drop), 64'd0);
    chk("reset_rd0", 64'(bus.read_data[31:0]), 64'd0);
    chk("reset_pend", 64'(bus.read_pending), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // write r3 and read it back
    set_rd(0, 3); set_rd(1, 0);
    #1 chk("r3_before_write", 64'(bus.read_data[31:0]), 64'd0);
    bus.wr_en = 1'b1; bus.write_addr = 4'd3; bus.write_data = 32'hDEAD_BEEF;
    cycle();
    bus.wr_en = 1'b0;
    #1 chk("r3_after_write", 64'(bus.read_data[31:0]), 64'hDEAD_BEEF);
    cycle();

    // same-cycle bypass on port1 only
    bus.wr_en = 1'b1; bus.write_addr = 4'd5; bus.write_data = 32'h1234_5678;
    set_rd(0, 6); set_rd(1, 5);
    #1;
    chk("bypass_p1_r5", 64'(bus.read_data[63:32]), 64'h1234_5678);
    chk("no_bypass_p0_r6", 64'(bus.read_data[31:0]), 64'd0);
    cycle();
    bus.wr_en = 1'b0;

    // scoreboard on r7
    bus.reserve_en = 1'b1; bus.reserve_addr = 4'd7; set_rd(0, 7);
    #1 chk("pend_r7_same_cycle", 64'(bus.read_pending[0]), 64'd0);
    cycle();
    bus.reserve_en = 1'b0;
    #1 chk("pend_r7_reserved", 64'(bus.read_pending[0]), 64'd1);
    bus.reserve_en = 1'b1; bus.wr_en = 1'b1; bus.write_addr = 4'd7; bus.write_data = 32'h77;
    cycle();
    bus.reserve_en = 1'b0; bus.wr_en = 1'b0;
    #1 chk("pend_r7_reserve_wins", 64'(bus.read_pending[0]), 64'd1);
    bus.wr_en = 1'b1;
    cycle();
    bus.wr_en = 1'b0;
    #1 chk("pend_r7_write_clears", 64'(bus.read_pending[0]), 64'd0);
    cycle();

    // fill, reserve, then clear sweep with a write during the sweep
    for (int i = 0; i < NREG; i++) begin
      bus.wr_en = 1'b1; bus.write_addr = 4'(i); bus.write_data = 32'hA500_0000 | 32'(i + 1);
      set_rd(0, i);
      cycle();
    end
    bus.wr_en = 1'b0;
    bus.reserve_en = 1'b1; bus.reserve_addr = 4'd4; cycle();
    bus.reserve_addr = 4'd9; cycle();
    bus.reserve_en = 1'b0;
    n_busy = 0; n_done = 0;
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) chk("wr_drop_in_sweep", 64'(bus.wr_drop), 64'd1);
      bus.wr_en = (i == 3); bus.write_addr = 4'd2; bus.write_data = 32'hFFFF_FFFF;
      bus.clear_req = (i == 6);
      set_rd(0, i % NREG); set_rd(1, 2);
      cycle();
    end
    drive_idle();
    chk("sweep_busy_cycles", 64'(n_busy), 64'd16);
    chk("clear_done_pulses", 64'(n_done), 64'd1);
    for (int a = 0; a < NREG; a++) begin
      set_rd(0, a); set_rd(1, NREG - 1 - a);
      cycle();
    end
    set_rd(0, 2);
    #1 chk("r2_zero_after_clear", 64'(bus.read_data[31:0]), 64'd0);

    // reset in the middle of a sweep
    bus.wr_en = 1'b1; bus.write_addr = 4'd1; bus.write_data = 32'hCAFE_0001;
    cycle();
    bus.wr_en = 1'b0;
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    bus.wr_en = 1'b1;
    repeat (5) cycle();
    bus.wr_en = 1'b0;
    set_rd(0, 1); set_rd(1, 9);
    reset = 1'b1;
    #1;
    chk("midsweep_reset_ready", 64'(bus.ready), 64'd1);
    chk("midsweep_reset_done", 64'(bus.clear_done), 64'd0);
    chk("midsweep_reset_drop", 64'(bus.wr_drop), 64'd0);
    chk("midsweep_reset_r1", 64'(bus.read_data[31:0]), 64'd0);
    chk("midsweep_reset_pend", 64'(bus.read_pending), 64'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    n_done = 0;
    repeat (20) cycle();
    chk("no_done_after_reset", 64'(n_done), 64'd0);

`ifdef REG_FILE_PC_READ_EN
    bus.pc_in = 32'h0000_0100; set_rd(0, 15); set_rd(1, 15);
    #1;
    chk("pc_read_p0", 64'(bus.read_data[31:0]), 64'h0000_0108);
    chk("pc_read_p1", 64'(bus.read_data[63:32]), 64'h0000_0108);
    bus.pc_in = 32'hFFFF_FFFC;
    #1 chk("pc_read_wrap", 64'(bus.read_data[31:0]), 64'h0000_0004);
    cycle();
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.clear_req    = ($urandom_range(0, 49) == 0);
      bus.wr_en        = bus.clear_req ? 1'b0 : ($urandom_range(0, 1) == 1);
      bus.write_addr   = 4'($urandom);
      bus.write_data   = $urandom;
      bus.reserve_en   = ($urandom_range(0, 2) == 0);
      bus.reserve_addr = 4'($urandom);
      bus.pc_in        = $urandom;
      for (int k = 0; k < NUM_RD; k++) begin
        if ($urandom_range(0, 3) == 0) set_rd(k, int'(bus.write_addr));
        else set_rd(k, int'($urandom_range(0, NREG - 1)));
      end
      cycle();
    end
    drive_idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_pipe.md
Name: reg_file_pipe

Overview:
- Parametrised register file for the pipelined CPU datapath.
- Generalised in data width, register count and read-port count.
- Adds same-cycle write-to-read bypass, a per-register pending scoreboard for hazard detection, and a sequential clear engine driven by an FSM.
- Sits in decode; it is written back from the WB stage.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 4, register address width; register count NREG = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- write_addr  in  ADDR_W  write register index.
- write_data  in  DATA_W  write value.
- read_addr  in  NUM_RD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W].
- read_data  out  NUM_RD*DATA_W  packed read values, same packing.
- read_pending  out  NUM_RD  1 = register addressed by port k has an outstanding reservation.
- reserve_en  in  1  mark reserve_addr pending (issued producer).
- reserve_addr  in  ADDR_W  register to reserve.
- clear_req  in  1  start a sequential clear of all registers.
- ready  out  1  1 = IDLE, accepting writes and reservations.
- clear_done  out  1  one-cycle pulse when the clear sweep completes.
- wr_drop  out  1  one-cycle pulse: a write or reservation arrived while busy and was discarded.
- pc_in  in  DATA_W  current PC; used only with the optional feature.

Behaviour:
- Reset (async, while asserted):
  - All registers = 0; all pending bits = 0.
  - FSM = IDLE; ready = 1; clear_done = 0; wr_drop = 0; sweep index = 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req = 1 on a rising edge. ready drops to 0 the following cycle.
  - CLEAR: one register per cycle, index 0..NREG-1. Each cycle writes the register to 0 and clears its pending bit.
  - CLEAR -> IDLE on the cycle index = NREG-1 is written. clear_done = 1 for the next cycle only; ready = 1 from that cycle.
  - Sweep takes exactly NREG cycles.
  - clear_req while in CLEAR is ignored (no restart).
  - Index wraps to 0 on exit.
- Writes in IDLE: if wr_en, register[write_addr] <= write_data at the rising edge.
- Writes while CLEAR (including the IDLE->CLEAR transition cycle): wr_en is dropped and wr_drop pulses the next cycle. The same applies to reserve_en.
- Reads:
  - Combinational, zero latency.
  - Bypass in IDLE only: if wr_en && write_addr == port address, read_data for that port = write_data in the same cycle. Otherwise the stored value.
  - In CLEAR: stored value, no bypass.
- Scoreboard:
  - reserve_en in IDLE sets pending[reserve_addr] at the edge.
  - wr_en in IDLE clears pending[write_addr].
  - Same edge, same address: reserve wins; pending stays 1.
  - read_pending[k] = pending[read_addr k], registered value only; no bypass of same-cycle reserve/write.
- Multiple ports on the same address return identical data and pending.
- Reset asserted mid-sweep: immediate return to the reset state; the sweep is abandoned and clear_done is not pulsed.

Optional Feature:
- Macro: REG_FILE_PC_READ_EN.
- Defined: read address NREG-1 returns pc_in + 8 (modulo 2**DATA_W) on every read port, with no bypass. read_pending for that address is forced to 0. Writes to NREG-1 still update storage but are unobservable on read.
- Undefined: NREG-1 is an ordinary register; pc_in is ignored.

Test Plan:
- Reset, then write 0xDEADBEEF to r3; next cycle read port0 = r3 -> read_data0 = 0xDEADBEEF. Before the write, r3 reads 0x00000000.
- Write 0x12345678 to r5 with port1 reading r5 in the same cycle -> read_data1 = 0x12345678 that cycle (bypass); port0 reading r6 is unaffected.
- reserve r7, then read r7 -> read_pending = 1. Reserve r7 and write r7 on the same edge -> still 1. Write r7 alone -> 0 the next cycle.
- Fill r0..r15 with nonzero values, pulse clear_req:
  - ready = 0 for 16 cycles, then clear_done pulses once and ready = 1.
  - All registers read 0 and all pending bits are 0.
  - A wr_en during the sweep yields a wr_drop pulse and no data change.
- Assert reset on sweep cycle 5 -> all outputs at reset values immediately; no clear_done pulse.
- With REG_FILE_PC_READ_EN and pc_in = 0x00000100, read r15 -> 0x00000108. With pc_in = 0xFFFFFFFC -> 0x00000004 (wrap).
